keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the 4x4 keypad columns and reads back the row inputs after they pass through the row synchronizer.
- Scans columns one at a time, debounces press and release, and emits one hex key code per physical press.
- Sits between the synchronizer's 4-bit output and the display/key-history logic.

Parameters:
- SETTLE_CYCLES, 2000: dwell cycles per column before rows are sampled (must be >= 1).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a press or a release (must be >= 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rows  input  4  synchronized keypad rows, active-low (0 = row pulled low by the driven column).
- cols  output  4  column drive, one-hot active-low.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high from acceptance until the release is debounced.

Behaviour:
- Reset (reset=0, asynchronous): cols=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, column index=0, counters=0.
- Key map (row,col). Row0: 1 2 3 A. Row1: 4 5 6 B. Row2: 7 8 9 C. Row3: E 0 F D.
- Column index c drives cols = ~(4'b0001<<c).
- SCAN state:
  - Dwell counter counts 0..SETTLE_CYCLES-1 for column c.
  - On the edge where counter==SETTLE_CYCLES-1, sample rows.
  - Exactly one row bit 0: latch row index and pattern, go to DEBOUNCE, counter=0, c unchanged.
  - Zero or more than one row bit 0: c=c+1 (3 wraps to 0), counter=0, stay in SCAN.
- DEBOUNCE state:
  - cols held at c.
  - Each cycle rows==latched pattern: counter+1. On the edge where counter reaches DEBOUNCE_CYCLES-1, go to HELD, assert key_valid for that one cycle, load key_code, set key_held=1.
  - Any mismatch: abort with no pulse, c=c+1, go to SCAN, counter=0.
- HELD state:
  - cols held at c. Stays while the latched row bit is 0.
  - Extra rows going low in the same column are ignored.
  - Keys in other columns are invisible because their columns are not driven.
  - Latched row bit goes to 1: go to RELEASE, counter=0.
- RELEASE state:
  - Each cycle the latched row bit is 1: counter+1. On reaching DEBOUNCE_CYCLES-1, clear key_held, c=c+1, go to SCAN.
  - Latched row bit returns to 0 before that: return to HELD with no new pulse and key_held still 1.
- Press latency: key_valid is high DEBOUNCE_CYCLES cycles after the sampling edge, given stable rows.
- Ordering: key_valid never re-pulses before key_held falls. key_code holds its value until the next accepted key.
- Counter width: $clog2(max(SETTLE_CYCLES,DEBOUNCE_CYCLES))+1. No overflow is possible because counters are cleared on every state change.
- Reset mid-operation from any state returns all outputs to reset values immediately, with no pending pulse.

Decomposition:
- Package keypad_pkg holds:
  - state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - typedef for the 2-bit row/col index;
  - the 16-entry key-map constant.
- One natural sub-module: keypad_decoder. It is combinational and maps (row index, col index) to the 4-bit code using the package map.
- FSM, counters and column rotation stay in keypad_scanner.

Test Plan (bench uses SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4; keypad model pulls a row low only when that key is pressed and its column is driven):
- Reset and idle scan: hold reset=0, check cols=1110, key_valid=0, key_code=0, key_held=0. Release reset with no keys, check cols cycles 1110->1101->1011->0111->1110, 2 cycles each.
- Clean press: press '5' (row1,col1) for 30 cycles, then release. Expect exactly one key_valid pulse with key_code=4'h5. key_held=1 and cols frozen at 1101 until 4 stable released cycles, after which scanning resumes at 1011.
- Press bounce: press '9' (row2,col2) for 2 cycles, then release. Expect no key_valid, key_code unchanged, scanning continues with col advanced.
- Ghost rejection: press '1' and '7' together (col0, rows 0 and 2) and expect no key_valid. Then press only 'D' (row3,col3) and expect a key_valid pulse with key_code=4'hD.
- Release bounce: after accepting 'A' (row0,col3), toggle row0 high 2 cycles, low 3 cycles, then high 5 cycles. Expect no second pulse; key_held falls only after the final 4 stable-high cycles; cols then goes to 1110.
- Async reset in HELD: while '0' is held (key_held=1), pulse reset low mid-cycle. Expect cols=1110, key_held=0, key_code=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the 4x4 key map for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  typedef logic [1:0] idx_t;

  // Indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/keypad_decoder.sv
// Maps a latched (row, col) key position to its hex code.
module keypad_decoder
  import keypad_pkg::*;
(
  input  idx_t       row,
  input  idx_t       col,
  output logic [3:0] code
);

  always_comb code = KEY_MAP[{row, col}];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one code per press.
//   state    | meaning
//   SCAN     | drive columns in turn, sample rows after the settle dwell
//   DEBOUNCE | one row seen low, waiting for a stable press
//   HELD     | press accepted, column frozen until the latched row rises
//   RELEASE  | latched row high, waiting for a stable release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 2000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  scan_state_t   state, state_nxt;
  idx_t          col, col_nxt;
  idx_t          row_idx, row_idx_nxt;
  idx_t          low_idx;
  logic [3:0]    row_pat, row_pat_nxt;
  logic [3:0]    row_low;
  logic [3:0]    dec_code, code_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          valid_nxt;
  logic          one_low;
  logic          latched_low;

  keypad_decoder u_decoder (
    .row  (row_idx),
    .col  (col),
    .code (dec_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= '0;
      cnt       <= '0;
      row_idx   <= '0;
      row_pat   <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      cnt       <= cnt_nxt;
      row_idx   <= row_idx_nxt;
      row_pat   <= row_pat_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
    end
  end

  always_comb begin
    row_low     = ~rows;
    one_low     = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
    latched_low = ~rows[row_idx];
    low_idx     = '0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) low_idx = idx_t'(i);
    end

    state_nxt   = state;
    col_nxt     = col;
    cnt_nxt     = cnt;
    row_idx_nxt = row_idx;
    row_pat_nxt = row_pat;
    code_nxt    = key_code;
    valid_nxt   = 1'b0;

    case (state)
      SCAN: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt = '0;
          // Multiple low rows in one column are ghosting; skip the column.
          if (one_low) begin
            row_idx_nxt = low_idx;
            row_pat_nxt = rows;
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows != row_pat) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          col_nxt   = col + 2'd1;
        end else if (cnt == DEBOUNCE_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          valid_nxt = 1'b1;
          code_nxt  = dec_code;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!latched_low) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (latched_low) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEBOUNCE_LAST) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          col_nxt   = col + 2'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    cols     = ~(4'b0001 << col);
    key_held = (state == HELD) || (state == RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner against a timing model of the keypad.
module tb_keypad_scanner;

  localparam int S = 2;
  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } ev_t;
  ev_t vq[$];

  keypad_scanner #(
    .SETTLE_CYCLES   (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[r*4+c]) rows[r] = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_code(input int r, input int c);
    string lay;
    int    ch;
    lay = "123A456B789CE0FD";
    ch  = int'(lay[r*4+c]);
    if (ch >= 48 && ch <= 57) return 4'(ch - 48);
    return 4'(ch - 55);
  endfunction

  function automatic logic [3:0] ref_cols(input int c);
    case (c % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    ev_t ev;
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) begin
      ev.cyc  = cyc;
      ev.code = key_code;
      vq.push_back(ev);
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    pressed = '0;
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    vq.delete();
  endtask

  // Key (r,c) pressed after edge st and seen low on edges st+1 .. st+hold.
  task automatic run_press(input int r, input int c, input int st, input int hold);
    int se, fall, k;
    bit seen, acc;
    do_reset();
    se = (c + 1) * S;
    while (se < st + 1) se += 4 * S;
    seen = (st + hold >= se);
    acc  = (st + hold >= se + D);
    step_to(st);
    pressed[r*4+c] = 1'b1;
    step_to(st + hold);
    pressed = '0;
    if (acc) begin
      fall = st + hold + 1 + D;
      step_to(fall - 1);
      check_eq("held_before_release", key_held, 1'b1);
      check_eq("cols_frozen", cols, ref_cols(c));
      step_to(fall);
      check_eq("held_after_release", key_held, 1'b0);
      check_eq("cols_resume", cols, ref_cols(c + 1));
      check_eq("pulse_count", vq.size(), 1);
      if (vq.size() > 0) begin
        check_eq("pulse_cycle", vq[0].cyc, se + D);
        check_eq("pulse_code", vq[0].code, ref_code(r, c));
      end
      check_eq("code_kept", key_code, ref_code(r, c));
    end else begin
      k = st + hold + 1;
      step_to(k);
      check_eq("cols_after_bounce", cols, seen ? ref_cols(c + 1) : ref_cols(k / S));
      check_eq("no_pulse", vq.size(), 0);
      check_eq("no_held", key_held, 1'b0);
      check_eq("code_unchanged", key_code, 4'h0);
    end
    step_to(cyc + 10);
    check_eq("no_extra_pulse", vq.size(), acc ? 1 : 0);
  endtask

  initial begin
    reset   = 1'b1;
    pressed = '0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_cols", cols, 4'b1110);
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_code", key_code, 4'h0);
    check_eq("rst_held", key_held, 1'b0);

    // Idle scan: each column dwells S cycles.
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    vq.delete();
    for (int k = 0; k < 10; k++) begin
      check_eq("idle_scan", cols, ref_cols(k / S));
      step();
    end
    check_eq("idle_no_pulse", vq.size(), 0);

    run_press(1, 1, 0, 30);   // clean '5'
    run_press(2, 2, 5, 2);    // bounce on '9'

    // Ghost: '1' and '7' share column 0.
    do_reset();
    pressed[0*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    step_to(20);
    check_eq("ghost_no_pulse", vq.size(), 0);
    check_eq("ghost_scan", cols, ref_cols(20 / S));
    check_eq("ghost_no_held", key_held, 1'b0);
    pressed = '0;
    run_press(3, 3, 0, 25);   // 'D'

    // Release bounce on 'A': accepted at 4*S+D, then high 2 / low 3 / high 5.
    do_reset();
    pressed[0*4+3] = 1'b1;
    step_to(20);
    check_eq("rb_held", key_held, 1'b1);
    pressed = '0;
    step_to(22);
    pressed[0*4+3] = 1'b1;
    step_to(25);
    check_eq("rb_still_held", key_held, 1'b1);
    pressed = '0;
    step_to(29);
    check_eq("rb_held_late", key_held, 1'b1);
    step_to(30);
    check_eq("rb_released", key_held, 1'b0);
    check_eq("rb_cols", cols, 4'b1110);
    check_eq("rb_pulses", vq.size(), 1);
    if (vq.size() > 0) begin
      check_eq("rb_pulse_cycle", vq[0].cyc, 4 * S + D);
      check_eq("rb_code", vq[0].code, ref_code(0, 3));
    end

    for (int i = 0; i < 12; i++) begin
      run_press($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(30, 1));
    end

    // Async reset while '0' is held.
    do_reset();
    pressed[3*4+1] = 1'b1;
    step_to(15);
    check_eq("ar_held", key_held, 1'b1);
    check_eq("ar_pulses", vq.size(), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_cols", cols, 4'b1110);
    check_eq("ar_held_cleared", key_held, 1'b0);
    check_eq("ar_code", key_code, 4'h0);
    check_eq("ar_valid", key_valid, 1'b0);
    pressed = '0;
    @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
